// File: rtl/ibex_instr_aligner.sv
// rtl/ibex_instr_aligner.sv - realigns word-aligned fetch data into 16/32-bit instructions
// Holds at most one pending upper halfword; tracks the PC and restarts on flush.
module ibex_instr_aligner #(
  parameter logic [31:0] BootAddr = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [31:0] flush_addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_addr_o,
  output logic        out_is_compressed_o,
  output logic        out_err_o,
  output logic        out_err_plus2_o
);

  typedef enum logic [1:0] {
    ALIGNED = 2'd0,
    HELD    = 2'd1,
    SKIP    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic        hold_err_q, hold_err_d;
  logic [31:1] pc_q, pc_d;

  logic        out_hs, in_hs, comp;
  logic        hold_comp, word_comp;

  assign hold_comp = (hold_q[1:0] != 2'b11);
  assign word_comp = (in_rdata_i[1:0] != 2'b11);

  assign out_addr_o          = {pc_q, 1'b0};
  assign comp                = (out_instr_o[1:0] != 2'b11);
  assign out_is_compressed_o = comp;
  assign out_hs              = out_valid_o & out_ready_i;
  assign in_hs               = in_valid_i & in_ready_o;

  always_comb begin
    out_valid_o     = 1'b0;
    in_ready_o      = 1'b0;
    out_instr_o     = in_rdata_i;
    out_err_o       = 1'b0;
    out_err_plus2_o = 1'b0;
    state_d         = state_q;
    hold_d          = hold_q;
    hold_err_d      = hold_err_q;
    pc_d            = pc_q;

    case (state_q)
      ALIGNED: begin
        out_valid_o = in_valid_i;
        in_ready_o  = out_ready_i;
        out_err_o   = in_err_i;
        out_instr_o = word_comp ? {16'h0, in_rdata_i[15:0]} : in_rdata_i;
      end
      HELD: begin
        if (hold_comp) begin
          out_valid_o = 1'b1;
          out_instr_o = {16'h0, hold_q};
          out_err_o   = hold_err_q;
        end else begin
          out_valid_o     = in_valid_i;
          in_ready_o      = out_ready_i;
          out_instr_o     = {in_rdata_i[15:0], hold_q};
          out_err_o       = hold_err_q | in_err_i;
          out_err_plus2_o = in_err_i & ~hold_err_q;
        end
      end
      SKIP: begin
        in_ready_o = 1'b1;
      end
      default: begin
        out_valid_o = 1'b0;
      end
    endcase

    // Flush overrides every handshake in the same cycle.
    if (flush_i) begin
      out_valid_o = 1'b0;
      in_ready_o  = 1'b0;
      pc_d        = flush_addr_i[31:1];
      hold_err_d  = 1'b0;
      state_d     = flush_addr_i[1] ? SKIP : ALIGNED;
    end else begin
      if (out_hs) begin
        pc_d = pc_q + (comp ? 31'd1 : 31'd2);
      end
      case (state_q)
        ALIGNED: begin
          if (out_hs && word_comp) begin
            hold_d     = in_rdata_i[31:16];
            hold_err_d = in_err_i;
            state_d    = HELD;
          end
        end
        HELD: begin
          if (out_hs) begin
            if (hold_comp) begin
              state_d = ALIGNED;
            end else begin
              hold_d     = in_rdata_i[31:16];
              hold_err_d = in_err_i;
            end
          end
        end
        SKIP: begin
          if (in_hs) begin
            hold_d     = in_rdata_i[31:16];
            hold_err_d = in_err_i;
            state_d    = HELD;
          end
        end
        default: begin
          state_d = ALIGNED;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ALIGNED;
      hold_q     <= 16'h0;
      hold_err_q <= 1'b0;
      pc_q       <= BootAddr[31:1];
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_err_q <= hold_err_d;
      pc_q       <= pc_d;
    end
  end

endmodule

// File: tb/tb_ibex_instr_aligner.sv
// tb/tb_ibex_instr_aligner.sv - directed self-checking bench for ibex_instr_aligner
module tb_ibex_instr_aligner;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic [31:0] flush_addr_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_rdata_i;
  logic        in_err_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic [31:0] out_addr_o;
  logic        out_is_compressed_o;
  logic        out_err_o;
  logic        out_err_plus2_o;

  int checks = 0;
  int errors = 0;

  ibex_instr_aligner #(.BootAddr(32'h0000_0080)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .flush_i             (flush_i),
    .flush_addr_i        (flush_addr_i),
    .in_valid_i          (in_valid_i),
    .in_ready_o          (in_ready_o),
    .in_rdata_i          (in_rdata_i),
    .in_err_i            (in_err_i),
    .out_valid_o         (out_valid_o),
    .out_ready_i         (out_ready_i),
    .out_instr_o         (out_instr_o),
    .out_addr_o          (out_addr_o),
    .out_is_compressed_o (out_is_compressed_o),
    .out_err_o           (out_err_o),
    .out_err_plus2_o     (out_err_plus2_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply inputs shortly after a rising edge and let the combinational path settle.
  task automatic drive(input logic v, input logic [31:0] d, input logic e,
                       input logic rdy, input logic fl, input logic [31:0] fa);
    in_valid_i   = v;
    in_rdata_i   = d;
    in_err_i     = e;
    out_ready_i  = rdy;
    flush_i      = fl;
    flush_addr_i = fa;
    #2;
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] instr, input logic [31:0] addr,
                            input logic cmp, input logic rdy, input logic err, input logic p2);
    check({tag, ".valid"}, {31'h0, out_valid_o}, 32'h1);
    check({tag, ".instr"}, out_instr_o, instr);
    check({tag, ".addr"}, out_addr_o, addr);
    check({tag, ".comp"}, {31'h0, out_is_compressed_o}, {31'h0, cmp});
    check({tag, ".in_ready"}, {31'h0, in_ready_o}, {31'h0, rdy});
    check({tag, ".err"}, {31'h0, out_err_o}, {31'h0, err});
    check({tag, ".plus2"}, {31'h0, out_err_plus2_o}, {31'h0, p2});
  endtask

  task automatic do_flush(input logic [31:0] fa);
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b1, 1'b1, fa);
    check("flush.valid", {31'h0, out_valid_o}, 32'h0);
    check("flush.in_ready", {31'h0, in_ready_o}, 32'h0);
    tick();
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    #20;
    check("rst.valid", {31'h0, out_valid_o}, 32'h0);
    check("rst.in_ready", {31'h0, in_ready_o}, 32'h0);
    check("rst.addr", out_addr_o, 32'h80);
    check("rst.err", {31'h0, out_err_o}, 32'h0);
    check("rst.plus2", {31'h0, out_err_plus2_o}, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // 32-bit instruction at BootAddr
    drive(1'b1, 32'h00A0_0513, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("boot", 32'h00A0_0513, 32'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("boot.next_addr", out_addr_o, 32'h84);
    check("boot.idle_valid", {31'h0, out_valid_o}, 32'h0);

    // Two compressed instructions in one word
    do_flush(32'h100);
    drive(1'b1, 32'h4501_4505, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("cc0", 32'h0000_4505, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00A0_0513, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("cc1", 32'h0000_4501, 32'h102, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("cc2", 32'h00A0_0513, 32'h104, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    // Straddling 32-bit instruction
    do_flush(32'h100);
    drive(1'b1, 32'h0513_4501, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("st0", 32'h0000_4501, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0001_00A0, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("st1", 32'h00A0_0513, 32'h102, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("st2", 32'h0000_0001, 32'h106, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // Flush to an odd halfword: SKIP bubble drops the lower half
    do_flush(32'h202);
    drive(1'b1, 32'h4505_FFFF, 1'b0, 1'b1, 1'b0, 32'h0);
    check("skip.valid", {31'h0, out_valid_o}, 32'h0);
    check("skip.in_ready", {31'h0, in_ready_o}, 32'h1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("skip.out", 32'h0000_4505, 32'h202, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("skip.next_addr", out_addr_o, 32'h204);

    // Error on the second word of a straddle
    do_flush(32'h300);
    drive(1'b1, 32'h0513_4501, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h0001_00A0, 1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("e2", 32'h00A0_0513, 32'h302, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("e2.tail", 32'h0000_0001, 32'h306, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();

    // Error on the first word only
    do_flush(32'h400);
    drive(1'b1, 32'h0513_4501, 1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("e1.c", 32'h0000_4501, 32'h400, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h0001_00A0, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("e1.st", 32'h00A0_0513, 32'h402, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("e1.tail", 32'h0000_0001, 32'h406, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // Downstream stall in the straddling case, then flush during the stall
    do_flush(32'h500);
    drive(1'b1, 32'h0513_4501, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h0001_00A0, 1'b0, 1'b0, 1'b0, 32'h0);
      expect_out("stall", 32'h00A0_0513, 32'h502, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    do_flush(32'h600);
    drive(1'b1, 32'h00A0_0513, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("restart", 32'h00A0_0513, 32'h600, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    // PC wraps past the top of the address space
    do_flush(32'hFFFF_FFFE);
    drive(1'b1, 32'h4505_FFFF, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("wrap", 32'h0000_4505, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("wrap.next_addr", out_addr_o, 32'h0);

    // Asynchronous reset mid-stream
    drive(1'b1, 32'h0513_4501, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    #1;
    rst_ni = 1'b0;
    out_ready_i = 1'b0;
    #1;
    check("areset.addr", out_addr_o, 32'h80);
    check("areset.valid", {31'h0, out_valid_o}, 32'h1);
    check("areset.instr", out_instr_o, 32'h0000_4501);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_instr_aligner.md
# ibex_instr_aligner

Halfword realignment stage between the fetch FIFO and the compressed decoder. It accepts 32-bit word-aligned fetch words and emits one instruction per handshake, left-aligned and with its address. An instruction is either a 16-bit compressed instruction or a 32-bit instruction, which may straddle two fetch words. It holds at most one pending upper halfword, tracks the PC, and handles branch flushes to halfword-aligned targets.

## Interface
- BootAddr, 32'h0000_0080: PC after reset; bit 0 ignored.
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous assertion, active-low
- flush_i  in  1  discard held state, restart at flush_addr_i
- flush_addr_i  in  32  new PC; bit 0 ignored
- in_valid_i  in  1  fetch word valid
- in_ready_o  out  1  fetch word consumed when in_valid_i & in_ready_o
- in_rdata_i  in  32  word-aligned fetch data
- in_err_i  in  1  bus error on this word
- out_valid_o  out  1  instruction valid
- out_ready_i  in  1  downstream accepts when out_valid_o & out_ready_i
- out_instr_o  out  32  instruction; compressed instructions are zero-extended in bits 31:16
- out_addr_o  out  32  instruction PC
- out_is_compressed_o  out  1  out_instr_o[1:0] != 2'b11
- out_err_o  out  1  fetch error on any part of the instruction
- out_err_plus2_o  out  1  error only on the upper half of a straddling instruction

## Operation

Registers:
- state_q ∈ {ALIGNED, HELD, SKIP}
- hold_q[15:0], hold_err_q
- pc_q[31:1]; pc_q[0] is always 0

Let w = in_rdata_i. On each out handshake, pc_q advances by +2 (compressed) or +4.

ALIGNED (next instruction starts at a word boundary):
- out_valid_o = in_valid_i; out_addr_o = pc_q.
- If w[1:0] != 11:
  - out_instr_o = {16'h0, w[15:0]}; out_err_o = in_err_i.
  - On handshake: word consumed, hold_q ← w[31:16], hold_err_q ← in_err_i, → HELD.
- If w[1:0] == 11:
  - out_instr_o = w; out_err_o = in_err_i.
  - On handshake: word consumed, stay ALIGNED.
- in_ready_o = out_ready_i.

HELD (next instruction starts at hold_q):
- If hold_q[1:0] != 11:
  - out_valid_o = 1; out_instr_o = {16'h0, hold_q}; out_err_o = hold_err_q; in_ready_o = 0.
  - On handshake → ALIGNED.
- If hold_q[1:0] == 11 (straddling):
  - out_valid_o = in_valid_i; out_instr_o = {w[15:0], hold_q}.
  - out_err_o = hold_err_q | in_err_i; out_err_plus2_o = in_err_i & ~hold_err_q.
  - in_ready_o = out_ready_i.
  - On handshake: hold_q ← w[31:16], hold_err_q ← in_err_i, stay HELD.

SKIP (flush target had bit 1 set):
- out_valid_o = 0; in_ready_o = 1.
- On input handshake: lower half dropped, hold_q ← w[31:16], hold_err_q ← in_err_i, → HELD.

Flush:
- flush_i has priority over all handshakes. That cycle: out_valid_o = 0, in_ready_o = 0, no handshake occurs.
- Next edge: pc_q ← flush_addr_i[31:1], hold_err_q ← 0, state ← flush_addr_i[1] ? SKIP : ALIGNED.
- Upstream drops its own in-flight data on flush.

Other rules:
- out_err_plus2_o = 0 outside the HELD-straddling case.
- An error word still yields an instruction; downstream takes the exception and flushes.
- pc_q wraps modulo 2^32.
- While out_valid_o & ~out_ready_i: no state change, and all outputs stay stable provided the inputs stay stable.

## Timing
- Reset values: state ALIGNED, pc_q = BootAddr & ~1, hold_q = 0, hold_err_q = 0.
- Output reset values: out_valid_o = 0, in_ready_o = 0 (out_ready_i = 0 assumed during reset), out_addr_o = BootAddr & ~1, out_err_o = 0, out_err_plus2_o = 0.
- Output path is combinational from in_* and registers: zero-cycle latency when data is present.
- Registered effects appear the cycle after the handshake.
- Throughput:
  - One instruction per cycle, except a compressed instruction in HELD, which takes a cycle without consuming input.
  - SKIP costs one bubble cycle.
- in_ready_o depends combinationally on out_ready_i; there is no path from out_ready_i to out_valid_o.
- Reset deasserting mid-stream, or asserting asynchronously, returns to ALIGNED at BootAddr; held data is lost.

## Test plan
- Reset, BootAddr=0x80, word 0x00A00513 (32-bit) → out_instr=0x00A00513, addr 0x80, compressed=0; next addr 0x84.
- Word 0x45014505 (two c.li) at 0x100 → out 0x00004505 @0x100 in cycle 1, then 0x00004501 @0x102 in cycle 2 with in_ready_o=0; next word fetched in cycle 3 @0x104.
- Straddle: words 0x05134501 then 0x000100A0 → out 0x4501 @0x100, then 0x00A00513 @0x102 (err=0), then hold=0x0001 @0x106.
- flush_i with flush_addr 0x202; word 0x4505FFFF → one bubble with the lower half dropped, then out 0x00004505 @0x202.
- Straddle with in_err_i=1 on the second word → out_err_o=1, out_err_plus2_o=1. Error on the first word only → out_err_o=1, out_err_plus2_o=0.
- out_ready_i held low 5 cycles in HELD-straddle → no input consumed, outputs stable; flush_i during the stall → out_valid_o=0 that cycle, then restart at the target.
